// File: rtl/warp_reconv_stack_if.sv
// Branch, fetch-redirect and warp_mask update signals of the SIMT reconvergence stack.
// The stack itself owns the master modport; branch resolution, fetch and warp_mask sit on slave.
interface warp_reconv_stack_if #(
   parameter int unsigned NUM_LANES   = 8,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned PC_WIDTH    = 32
);
   localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);

   logic                 branch_valid;
   logic                 branch_ready;
   logic [NUM_LANES-1:0] branch_taken;
   logic [PC_WIDTH-1:0]  branch_target;
   logic [PC_WIDTH-1:0]  branch_fallthru;
   logic [PC_WIDTH-1:0]  branch_reconv;
   logic                 pc_valid;
   logic [PC_WIDTH-1:0]  pc;
   logic [NUM_LANES-1:0] active_mask;
   logic                 mask_update;
   logic [NUM_LANES-1:0] mask_in;
   logic                 redirect_valid;
   logic                 redirect_ready;
   logic [PC_WIDTH-1:0]  redirect_pc;
   logic                 busy;
   logic [DepthW-1:0]    depth;
   logic                 overflow;

   modport master (
      input  branch_valid, branch_taken, branch_target, branch_fallthru, branch_reconv,
      input  pc_valid, pc, active_mask, redirect_ready,
      output branch_ready, mask_update, mask_in, redirect_valid, redirect_pc, busy, depth, overflow
   );

   modport slave (
      output branch_valid, branch_taken, branch_target, branch_fallthru, branch_reconv,
      output pc_valid, pc, active_mask, redirect_ready,
      input  branch_ready, mask_update, mask_in, redirect_valid, redirect_pc, busy, depth, overflow
   );
endinterface

// File: rtl/warp_reconv_stack.sv
// SIMT divergence/reconvergence stack: pushes the pending path on a divergent branch and
// switches to it, or pops and restores the pre-branch mask, when fetch reaches the reconvergence PC.
module warp_reconv_stack #(
   parameter int unsigned NUM_LANES   = 8,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned PC_WIDTH    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   warp_reconv_stack_if.master bus
);
   localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IdxW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [DepthW-1:0] FullDepth = DepthW'(STACK_DEPTH);

   typedef enum logic [1:0] {StIdle, StIssue, StWaitRdy} state_e;

   state_e               state_q;
   logic [DepthW-1:0]    depth_q;
   logic                 overflow_q;
   logic                 mask_update_q;
   logic [NUM_LANES-1:0] mask_in_q;
   logic                 redirect_valid_q;
   logic [PC_WIDTH-1:0]  redirect_pc_q;

   logic [PC_WIDTH-1:0]  reconv_pc_q  [STACK_DEPTH];
   logic [NUM_LANES-1:0] rejoin_q     [STACK_DEPTH];
   logic [NUM_LANES-1:0] pend_mask_q  [STACK_DEPTH];
   logic [PC_WIDTH-1:0]  pend_pc_q    [STACK_DEPTH];

   logic [IdxW-1:0]      top_idx;
   logic [IdxW-1:0]      push_idx;
   logic [NUM_LANES-1:0] taken_m;
   logic [NUM_LANES-1:0] not_taken_m;
   logic                 reconv_hit;
   logic                 pend_nz;
   logic                 br_acc;
   logic                 uniform_nt;
   logic                 uniform_t;
   logic                 full;
   logic                 push;

   always_comb begin
      top_idx     = IdxW'(depth_q - DepthW'(1));
      push_idx    = IdxW'(depth_q);
      taken_m     = bus.branch_taken & bus.active_mask;
      not_taken_m = ~bus.branch_taken & bus.active_mask;
      reconv_hit  = bus.pc_valid && (depth_q != '0) && (bus.pc == reconv_pc_q[top_idx]);
      pend_nz     = (pend_mask_q[top_idx] != '0);
      bus.branch_ready = (state_q == StIdle) && !reconv_hit;
      br_acc      = bus.branch_valid && bus.branch_ready;
      // An all-zero active mask counts as uniform not-taken, never as divergent.
      uniform_nt  = (taken_m == '0);
      uniform_t   = !uniform_nt && (taken_m == bus.active_mask);
      full        = (depth_q == FullDepth);
      push        = br_acc && !uniform_nt && !uniform_t && !full;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= StIdle;
         depth_q          <= '0;
         overflow_q       <= 1'b0;
         mask_update_q    <= 1'b0;
         mask_in_q        <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (reconv_hit) begin
                  state_q          <= StIssue;
                  mask_update_q    <= 1'b1;
                  mask_in_q        <= pend_nz ? pend_mask_q[top_idx] : rejoin_q[top_idx];
                  redirect_valid_q <= pend_nz;
                  redirect_pc_q    <= pend_nz ? pend_pc_q[top_idx] : '0;
                  if (!pend_nz) depth_q <= depth_q - DepthW'(1);
               end else if (br_acc && uniform_t) begin
                  state_q          <= StIssue;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= bus.branch_target;
               end else if (push) begin
                  state_q          <= StIssue;
                  depth_q          <= depth_q + DepthW'(1);
                  mask_update_q    <= 1'b1;
                  mask_in_q        <= taken_m;
                  redirect_valid_q <= 1'b1;
                  redirect_pc_q    <= bus.branch_target;
               end else if (br_acc && !uniform_nt && full) begin
                  overflow_q <= 1'b1;
               end
            end
            StIssue: begin
               mask_update_q <= 1'b0;
               if (!redirect_valid_q || bus.redirect_ready) begin
                  state_q          <= StIdle;
                  mask_in_q        <= '0;
                  redirect_valid_q <= 1'b0;
                  redirect_pc_q    <= '0;
               end else begin
                  state_q <= StWaitRdy;
               end
            end
            StWaitRdy: begin
               if (bus.redirect_ready) begin
                  state_q          <= StIdle;
                  mask_in_q        <= '0;
                  redirect_valid_q <= 1'b0;
                  redirect_pc_q    <= '0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Stack contents need no reset: depth_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (rst_n && state_q == StIdle) begin
         if (reconv_hit && pend_nz) begin
            pend_mask_q[top_idx] <= '0;
         end else if (push) begin
            reconv_pc_q[push_idx] <= bus.branch_reconv;
            rejoin_q[push_idx]    <= bus.active_mask;
            pend_mask_q[push_idx] <= not_taken_m;
            pend_pc_q[push_idx]   <= bus.branch_fallthru;
         end
      end
   end

   assign bus.mask_update    = mask_update_q;
   assign bus.mask_in        = mask_in_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.busy           = (state_q != StIdle);
   assign bus.depth          = depth_q;
   assign bus.overflow       = overflow_q;
endmodule
